// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: register index width, opcode encodings,
// immediate formats and the per-opcode classification used by decode.
package riscv_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_REGS  = 32;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic     legal;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     writes_rd;
    imm_fmt_e fmt;
  } op_class_t;

  // Fields of the instruction held in the decode pipeline register.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    reg_idx_t    rs1;
    reg_idx_t    rs2;
    reg_idx_t    rd;
    logic [31:0] imm;
    logic        reg_write;
    logic        illegal;
  } decoded_t;

  function automatic op_class_t classify(input logic [6:0] op);
    op_class_t c;
    c = '{1'b0, 1'b0, 1'b0, 1'b0, IMM_NONE};
    case (op)
      OPC_LUI:    c = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_U};
      OPC_AUIPC:  c = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_U};
      OPC_JAL:    c = '{1'b1, 1'b0, 1'b0, 1'b1, IMM_J};
      OPC_JALR:   c = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_BRANCH: c = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_B};
      OPC_LOAD:   c = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_STORE:  c = '{1'b1, 1'b1, 1'b1, 1'b0, IMM_S};
      OPC_OP_IMM: c = '{1'b1, 1'b1, 1'b0, 1'b1, IMM_I};
      OPC_OP:     c = '{1'b1, 1'b1, 1'b1, 1'b1, IMM_NONE};
      default:    c = '{1'b0, 1'b0, 1'b0, 1'b0, IMM_NONE};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bundle: fetch handshake, decoded outputs towards execute,
// writeback retire notification, flush and the pending-register view.
interface decode_stage_if;
  import riscv_pkg::*;

  logic                instrValid;
  logic [31:0]         instr;
  logic                instrReady;
  logic                outValid;
  logic                outReady;
  reg_idx_t            readReg1;
  reg_idx_t            readReg2;
  reg_idx_t            writeReg;
  logic                regWrite;
  logic [31:0]         imm;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                illegal;
  logic                wbValid;
  reg_idx_t            wbReg;
  logic                flush;
  logic [NUM_REGS-1:0] pending;

  modport slave (
    input  instrValid, instr, outReady, wbValid, wbReg, flush,
    output instrReady, outValid, readReg1, readReg2, writeReg, regWrite,
           imm, opcode, funct3, funct7, illegal, pending
  );

  modport master (
    output instrValid, instr, outReady, wbValid, wbReg, flush,
    input  instrReady, outValid, readReg1, readReg2, writeReg, regWrite,
           imm, opcode, funct3, funct7, illegal, pending
  );

endinterface

// File: rtl/decode_stage_scoreboard.sv
// Register scoreboard: one pending bit per architectural register (x0 never
// pending) plus RAW hazard lookup for the two source operands of a new instruction.
module decode_stage_scoreboard
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  logic                held_valid,
  input  logic                held_wr,
  input  reg_idx_t            held_idx,
  input  logic                use_rs1,
  input  reg_idx_t            rs1,
  input  logic                use_rs2,
  input  reg_idx_t            rs2,
  output logic                hazard,
  output logic [NUM_REGS-1:0] pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic                clr_live;
  logic                busy1;
  logic                busy2;

  // Clear is applied before set so a same-cycle set of the same register wins.
  always_comb begin
    clr_live = clr_en && (clr_idx != '0);
    set_vec  = '0;
    clr_vec  = '0;
    if (set_en)   set_vec[set_idx] = 1'b1;
    if (clr_live) clr_vec[clr_idx] = 1'b1;
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // A retiring write bypasses its own pending bit; the held instruction counts
  // as in flight because it is about to (or will) set its destination.
  always_comb begin
    busy1  = (pending_q[rs1] && !(clr_live && clr_idx == rs1)) ||
             (held_valid && held_wr && held_idx == rs1);
    busy2  = (pending_q[rs2] && !(clr_live && clr_idx == rs2)) ||
             (held_valid && held_wr && held_idx == rs2);
    hazard = (use_rs1 && (rs1 != '0) && busy1) ||
             (use_rs2 && (rs2 != '0) && busy2);
  end

  assign pending = pending_q;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry pipeline register holding the decoded
// instruction, with scoreboard-based RAW stall and flush support.
module decode_stage
  import riscv_pkg::*;
(
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave dec
);

  op_class_t   cls;
  decoded_t    dec_in;
  decoded_t    held_q;
  logic        valid_q;
  logic [31:0] imm_in;
  logic        hazard;
  logic        accept;
  logic        handshake;
  logic [31:0] w;

  always_comb begin
    w   = dec.instr;
    cls = classify(w[6:0]);
    case (cls.fmt)
      IMM_I:   imm_in = {{20{w[31]}}, w[31:20]};
      IMM_S:   imm_in = {{20{w[31]}}, w[31:25], w[11:7]};
      IMM_B:   imm_in = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      IMM_U:   imm_in = {w[31:12], 12'b0};
      IMM_J:   imm_in = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm_in = '0;
    endcase
    dec_in.opcode    = w[6:0];
    dec_in.funct3    = w[14:12];
    dec_in.funct7    = w[31:25];
    dec_in.rs1       = w[19:15];
    dec_in.rs2       = w[24:20];
    dec_in.rd        = w[11:7];
    dec_in.imm       = imm_in;
    dec_in.reg_write = cls.writes_rd && (w[11:7] != '0);
    dec_in.illegal   = !cls.legal;
  end

  assign dec.instrReady = !hazard && (!valid_q || dec.outReady) && !dec.flush;
  assign accept         = dec.instrValid && dec.instrReady;
  assign handshake      = valid_q && dec.outReady && !dec.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      held_q  <= '0;
    end else begin
      if (dec.flush)     valid_q <= 1'b0;
      else if (accept)   valid_q <= 1'b1;
      else if (handshake) valid_q <= 1'b0;
      if (accept) held_q <= dec_in;
    end
  end

  decode_stage_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (handshake && held_q.reg_write),
    .set_idx    (held_q.rd),
    .clr_en     (dec.wbValid),
    .clr_idx    (dec.wbReg),
    .held_valid (valid_q),
    .held_wr    (held_q.reg_write),
    .held_idx   (held_q.rd),
    .use_rs1    (cls.uses_rs1),
    .rs1        (dec_in.rs1),
    .use_rs2    (cls.uses_rs2),
    .rs2        (dec_in.rs2),
    .hazard     (hazard),
    .pending    (dec.pending)
  );

  assign dec.outValid = valid_q;
  assign dec.readReg1 = held_q.rs1;
  assign dec.readReg2 = held_q.rs2;
  assign dec.writeReg = held_q.rd;
  assign dec.regWrite = held_q.reg_write;
  assign dec.imm      = held_q.imm;
  assign dec.opcode   = held_q.opcode;
  assign dec.funct3   = held_q.funct3;
  assign dec.funct7   = held_q.funct7;
  assign dec.illegal  = held_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected decodes into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_decode_stage;
  import riscv_pkg::*;

  typedef struct {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        use1;
    logic [4:0]  rr1;
    logic        use2;
    logic [4:0]  rr2;
    logic [4:0]  wr;
    logic        rw;
    logic        ill;
    logic [31:0] imm;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  decode_stage_if ifc ();

  decode_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic u1, input logic [4:0] r1, input logic u2,
                              input logic [4:0] r2, input logic [4:0] wr, input logic rw,
                              input logic ill, input logic [31:0] imm);
    exp_t e;
    e.opcode = op; e.funct3 = f3; e.funct7 = f7;
    e.use1 = u1; e.rr1 = r1; e.use2 = u2; e.rr2 = r2;
    e.wr = wr; e.rw = rw; e.ill = ill; e.imm = imm;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every real output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.outValid && ifc.outReady && !ifc.flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {25'b0, ifc.opcode}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("opcode", {25'b0, ifc.opcode}, {25'b0, e.opcode});
        check("funct3", {29'b0, ifc.funct3}, {29'b0, e.funct3});
        check("funct7", {25'b0, ifc.funct7}, {25'b0, e.funct7});
        check("imm", ifc.imm, e.imm);
        check("regWrite", {31'b0, ifc.regWrite}, {31'b0, e.rw});
        check("illegal", {31'b0, ifc.illegal}, {31'b0, e.ill});
        if (e.use1) check("readReg1", {27'b0, ifc.readReg1}, {27'b0, e.rr1});
        if (e.use2) check("readReg2", {27'b0, ifc.readReg2}, {27'b0, e.rr2});
        if (e.rw)   check("writeReg", {27'b0, ifc.writeReg}, {27'b0, e.wr});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ifc.instrValid = 1'b0;
    ifc.instr      = '0;
    ifc.outReady   = 1'b1;
    ifc.wbValid    = 1'b0;
    ifc.wbReg      = '0;
    ifc.flush      = 1'b0;
    #3;
    check("rst_outValid", {31'b0, ifc.outValid}, 32'd0);
    check("rst_pending", ifc.pending, 32'd0);
    check("rst_imm", ifc.imm, 32'd0);
    check("rst_writeReg", {27'b0, ifc.writeReg}, 32'd0);
    #19 rst_n = 1'b1;
    step();

    // addi x1,x0,5 then add x2,x1,x1 back-to-back
    ifc.instrValid = 1'b1;
    ifc.instr = 32'h0050_0093;
    @(negedge clk);
    check("ready_after_reset", {31'b0, ifc.instrReady}, 32'd1);
    exp_q.push_back(mk(7'h13, 3'd0, 7'h00, 1'b1, 5'd0, 1'b0, 5'd0, 5'd1, 1'b1, 1'b0, 32'd5));
    step();
    ifc.instr = 32'h0010_8133;
    @(negedge clk);
    check("raw_held_stall", {31'b0, ifc.instrReady}, 32'd0);
    step();
    @(negedge clk);
    check("pending_x1", ifc.pending, 32'h0000_0002);
    check("raw_pending_stall", {31'b0, ifc.instrReady}, 32'd0);
    step();
    @(negedge clk);
    check("raw_still_stalled", {31'b0, ifc.instrReady}, 32'd0);
    step();
    ifc.wbValid = 1'b1;
    ifc.wbReg = 5'd1;
    @(negedge clk);
    check("wb_bypass_ready", {31'b0, ifc.instrReady}, 32'd1);
    exp_q.push_back(mk(7'h33, 3'd0, 7'h00, 1'b1, 5'd1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 32'd0));
    step();
    ifc.wbValid = 1'b0;
    ifc.instrValid = 1'b0;
    @(negedge clk);
    check("x1_cleared", ifc.pending, 32'd0);
    step();
    @(negedge clk);
    check("pending_x2", ifc.pending, 32'h0000_0004);
    step();
    ifc.wbValid = 1'b1;
    ifc.wbReg = 5'd2;
    step();
    ifc.wbValid = 1'b0;

    // sw x2,-4(x3) followed immediately by an illegal word
    ifc.instrValid = 1'b1;
    ifc.instr = 32'hFE21_AE23;
    @(negedge clk);
    check("sw_ready", {31'b0, ifc.instrReady}, 32'd1);
    exp_q.push_back(mk(7'h23, 3'd2, 7'h7F, 1'b1, 5'd3, 1'b1, 5'd2, 5'd0, 1'b0, 1'b0, 32'hFFFF_FFFC));
    step();
    ifc.instr = 32'hFFFF_FFFF;
    @(negedge clk);
    check("illegal_ready", {31'b0, ifc.instrReady}, 32'd1);
    exp_q.push_back(mk(7'h7F, 3'd7, 7'h7F, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 32'd0));
    step();
    ifc.instrValid = 1'b0;
    step();
    @(negedge clk);
    check("illegal_no_pending", ifc.pending, 32'd0);
    step();

    // addi x7,x0,1 leaves a pending bit that must survive the later flush
    ifc.instrValid = 1'b1;
    ifc.instr = 32'h0010_0393;
    @(negedge clk);
    exp_q.push_back(mk(7'h13, 3'd0, 7'h00, 1'b1, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1, 1'b0, 32'd1));
    step();
    ifc.instrValid = 1'b0;
    step();
    @(negedge clk);
    check("pending_x7", ifc.pending, 32'h0000_0080);
    step();

    // downstream stall for three cycles, then flush together with outReady
    ifc.outReady = 1'b0;
    ifc.instrValid = 1'b1;
    ifc.instr = 32'h0070_0293;
    @(negedge clk);
    check("stall_accept", {31'b0, ifc.instrReady}, 32'd1);
    step();
    ifc.instr = 32'h0010_0313;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_outValid", {31'b0, ifc.outValid}, 32'd1);
      check("stall_writeReg", {27'b0, ifc.writeReg}, 32'd5);
      check("stall_imm", ifc.imm, 32'd7);
      check("stall_ready", {31'b0, ifc.instrReady}, 32'd0);
      step();
    end
    ifc.flush = 1'b1;
    ifc.outReady = 1'b1;
    @(negedge clk);
    check("flush_ready_low", {31'b0, ifc.instrReady}, 32'd0);
    step();
    ifc.flush = 1'b0;
    ifc.instrValid = 1'b0;
    @(negedge clk);
    check("flush_outValid", {31'b0, ifc.outValid}, 32'd0);
    check("flush_pending_kept", ifc.pending, 32'h0000_0080);
    step();

    // addi x0,x0,1 stream then add x3,x0,x0: one per cycle, no hazards
    ifc.instrValid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      ifc.instr = (i < 4) ? 32'h0010_0013 : 32'h0000_01B3;
      @(negedge clk);
      check("stream_ready", {31'b0, ifc.instrReady}, 32'd1);
      if (i < 4) begin
        check("x0_never_pending", ifc.pending, 32'h0000_0080);
        exp_q.push_back(mk(7'h13, 3'd0, 7'h00, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 32'd1));
      end else begin
        exp_q.push_back(mk(7'h33, 3'd0, 7'h00, 1'b1, 5'd0, 1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 32'd0));
      end
      step();
    end
    ifc.instrValid = 1'b0;
    step();
    @(negedge clk);
    check("pending_x3_x7", ifc.pending, 32'h0000_0088);
    step();

    // lui x9 whose unused rs1 field names pending x7: must not stall
    ifc.instrValid = 1'b1;
    ifc.instr = 32'h0003_84B7;
    @(negedge clk);
    check("unused_rs_no_hazard", {31'b0, ifc.instrReady}, 32'd1);
    exp_q.push_back(mk(7'h37, 3'd0, 7'h00, 1'b0, 5'd0, 1'b0, 5'd0, 5'd9, 1'b1, 1'b0, 32'h0003_8000));
    step();
    ifc.instrValid = 1'b0;
    step();
    @(negedge clk);
    check("pending_x9", ifc.pending, 32'h0000_0288);
    step();

    // asynchronous reset while an instruction is held
    ifc.outReady = 1'b0;
    ifc.instrValid = 1'b1;
    ifc.instr = 32'h0070_0293;
    step();
    ifc.instrValid = 1'b0;
    @(negedge clk);
    check("held_before_reset", {31'b0, ifc.outValid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_outValid", {31'b0, ifc.outValid}, 32'd0);
    check("async_pending", ifc.pending, 32'd0);
    check("async_imm", ifc.imm, 32'd0);
    check("async_regWrite", {31'b0, ifc.regWrite}, 32'd0);
    check("async_readReg1", {27'b0, ifc.readReg1}, 32'd0);
    check("async_opcode", {25'b0, ifc.opcode}, 32'd0);
    step();
    rst_n = 1'b1;
    ifc.outReady = 1'b1;
    step();
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: none; all widths fixed (RV32I, 32 architectural registers).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 instrValid  in  1  upstream fetch offers instr.
REQ-005 instr  in  32  RV32I instruction word.
REQ-006 instrReady  out  1  decode accepts instr this cycle.
REQ-007 outValid  out  1  decoded instruction held on outputs.
REQ-008 outReady  in  1  downstream (execute) consumes outputs.
REQ-009 readReg1, readReg2  out  5 each  rs1/rs2 of held instruction; drive regfile read ports.
REQ-010 writeReg  out  5  rd of held instruction; regWrite  out  1  held instruction writes rd.
REQ-011 imm  out  32  sign-extended immediate; opcode  out  7; funct3  out  3; funct7  out  7.
REQ-012 illegal  out  1  held opcode not in supported set.
REQ-013 wbValid  in  1  writeback retires a register write this cycle; wbReg  in  5  its register.
REQ-014 flush  in  1  discard held instruction.

Function
REQ-015 One-entry pipeline register; accept when instrValid && instrReady; outValid rises the cycle after acceptance.
REQ-016 instrReady = !hazard && (!outValid || outReady); flush forces instrReady=0 that cycle.
REQ-017 Output handshake = outValid && outReady; outputs stable while outValid && !outReady.
REQ-018 Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
REQ-019 Immediate format: I (JALR, LOAD, OP-IMM), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); all sign-extended from instr[31]; illegal/OP gives imm=0.
REQ-020 rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2 used by BRANCH, STORE, OP.
REQ-021 regWrite=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd!=0; illegal forces regWrite=0, illegal=1.
REQ-022 Scoreboard: 32-bit pending vector; bit 0 hard-wired 0.
REQ-023 Pending[writeReg] set on output handshake when regWrite=1.
REQ-024 Pending[wbReg] cleared when wbValid && wbReg!=0.
REQ-025 Same-cycle set and clear of same register: set wins.
REQ-026 hazard = incoming instr uses rs (per REQ-020), rs!=0, and rs is (pending && !(wbValid && wbReg==rs)) or (outValid && regWrite && writeReg==rs).
REQ-027 Unused source fields never cause hazard; x0 never causes hazard.
REQ-028 flush: outValid cleared next edge; no scoreboard set for flushed instruction; pending bits of earlier issued instructions retained.
REQ-029 flush and outReady same cycle: flush wins, no handshake, no scoreboard set.
REQ-030 Zero-bubble throughput: back-to-back independent instructions accepted every cycle while outReady=1.

Reset
REQ-031 rst_n low: outValid=0, pending=0, readReg1/readReg2/writeReg=0, imm=0, opcode/funct3/funct7=0, regWrite=0, illegal=0, immediately and asynchronously.
REQ-032 After rst_n release with instrValid=1 and no hazard, instrReady=1 in the first cycle.
REQ-033 Reset mid-operation discards held instruction and all pending bits.

Structure
REQ-034 Shared package riscv_pkg: opcode constants, immediate-format enum, register-index width.
REQ-035 One sub-module: scoreboard (pending vector, set/clear, hazard lookup for two sources); immediate generation stays in decode_stage.

Verification
REQ-036 Reset, then instr=0x00500093 (addi x1,x0,5), outReady=1 -> outValid next cycle, writeReg=1, imm=5, regWrite=1, pending[1]=1 after handshake.
REQ-037 addi x1 then add x2,x1,x1 (0x00108133) back-to-back -> instrReady=0 until wbValid=1,wbReg=1; accepted that same cycle.
REQ-038 sw x2,-4(x3) (0xFE21AE23) -> imm=0xFFFFFFFC, regWrite=0, readReg1=3, readReg2=2.
REQ-039 instr=0xFFFFFFFF -> illegal=1, regWrite=0, no pending bit set.
REQ-040 Hold outReady=0 three cycles with outValid=1 -> outputs unchanged, instrReady=0; flush -> outValid=0 next cycle, pending unchanged.
REQ-041 addi x0,x0,1 repeated, then add x3,x0,x0 -> no hazard, one instruction per cycle, pending stays 0.
